// File: rtl/mips_lsu_pkg.sv
// Shared encodings for the MIPS load/store unit: access sizes, FSM states, lane helpers.
package mips_lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } size_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    STORE  = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam logic [31:0] BYTE_MASK = 32'h0000_00ff;
  localparam logic [31:0] HALF_MASK = 32'h0000_ffff;

  // Bit offset of the addressed lane; halves use addr[1] only, words always start at bit 0.
  function automatic logic [4:0] lane_shift(input size_t size, input logic [1:0] lane);
    case (size)
      SIZE_BYTE: return {lane, 3'b000};
      SIZE_HALF: return {lane[1], 4'b0000};
      default:   return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: extracts/extends load data and merges store data into a word.
module lsu_lane_align
  import mips_lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  size_t       size,
  input  logic        zero_ext,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [4:0]  shift;
  logic [15:0] lane_bits;

  always_comb begin
    shift      = lane_shift(size, lane);
    lane_bits  = 16'(word >> shift);
    load_data  = '0;
    store_word = wdata;
    case (size)
      SIZE_BYTE: begin
        load_data  = {{24{~zero_ext & lane_bits[7]}}, lane_bits[7:0]};
        store_word = (word & ~(BYTE_MASK << shift)) | ((wdata & BYTE_MASK) << shift);
      end
      SIZE_HALF: begin
        load_data  = {{16{~zero_ext & lane_bits[15]}}, lane_bits};
        store_word = (word & ~(HALF_MASK << shift)) | ((wdata & HALF_MASK) << shift);
      end
      SIZE_WORD: begin
        load_data  = word;
        store_word = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_load_store_unit.sv
// MIPS data-memory initiator: one request at a time, sub-word stores via read-modify-write.
// Define LSU_ALIGN_CHECK_EN to flag misaligned half/word accesses instead of force-aligning them.
module mips_load_store_unit
  import mips_lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEMORY_DEPTH = 256,
  parameter int unsigned ADDR_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  state_t                state;
  size_t                 req_sz;
  size_t                 cap_size;
  logic [1:0]            cap_lane;
  logic                  cap_unsigned;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  range_err;
  logic                  align_err;
  logic                  req_err;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] store_word;

  assign req_sz    = size_t'(req_size);
  assign word_idx  = req_addr >> 2;
  assign range_err = word_idx >= ADDR_WIDTH'(MEMORY_DEPTH);

`ifdef LSU_ALIGN_CHECK_EN
  assign align_err = ((req_sz == SIZE_HALF) && req_addr[0]) ||
                     ((req_sz == SIZE_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign align_err = 1'b0;
`endif

  assign req_err   = (req_sz == SIZE_ILLEGAL) || range_err || align_err;
  assign req_ready = (state == IDLE);

  lsu_lane_align u_align (
    .word       (mem_rdata),
    .lane       (cap_lane),
    .size       (cap_size),
    .zero_ext   (cap_unsigned),
    .wdata      (cap_wdata),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // Strobes are registered alongside the state transition so each output is a pure flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cap_size     <= SIZE_BYTE;
      cap_lane     <= '0;
      cap_unsigned <= 1'b0;
      cap_wdata    <= '0;
      resp_valid   <= 1'b0;
      resp_error   <= 1'b0;
      resp_rdata   <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_write    <= 1'b0;
      mem_read     <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_size     <= req_sz;
            cap_lane     <= req_addr[1:0];
            cap_unsigned <= req_unsigned;
            cap_wdata    <= req_wdata;
            resp_rdata   <= '0;
            resp_error   <= 1'b0;
            if (req_err) begin
              resp_error <= 1'b1;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              mem_addr <= DATA_WIDTH'(word_idx);
              if (!req_write) begin
                mem_read <= 1'b1;
                state    <= LOAD;
              end else if (req_sz == SIZE_WORD) begin
                mem_wdata <= req_wdata;
                mem_write <= 1'b1;
                state     <= STORE;
              end else begin
                mem_read <= 1'b1;
                state    <= RMW_RD;
              end
            end
          end
        end
        LOAD: begin
          resp_rdata <= load_data;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RMW_RD: begin
          mem_wdata <= store_word;
          mem_write <= 1'b1;
          state     <= STORE;
        end
        STORE: begin
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_load_store_unit.sv
// Scoreboard bench for mips_load_store_unit against a byte-addressed reference memory model.
module tb_mips_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  logic        write_seen = 1'b0;

  logic [31:0] mem [256];
  logic [7:0]  ref_b [1024];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned lat;
    int unsigned acc;
  } exp_t;
  exp_t q[$];

  mips_load_store_unit #(.DATA_WIDTH(32), .MEMORY_DEPTH(256), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write) write_seen <= 1'b1;
    if (mem_write && mem_addr < 32'd256) mem[mem_addr[7:0]] <= mem_wdata;
  end

  assign mem_rdata = (mem_read && mem_addr < 32'd256) ? mem[mem_addr[7:0]] : 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int unsigned idx);
    return {ref_b[4*idx+3], ref_b[4*idx+2], ref_b[4*idx+1], ref_b[4*idx]};
  endfunction

  // Reference behaviour: little-endian byte memory, accesses aligned down to their natural size.
  task automatic model(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic err, output int unsigned lat);
    int unsigned n, base;
    logic [31:0] v;
    n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    err = (sz == 2'b11) || ((addr >> 2) >= 32'd256);
`ifdef LSU_ALIGN_CHECK_EN
    if (sz != 2'b11 && (addr % n) != 0) err = 1'b1;
`endif
    rd = 32'h0;
    if (err) begin
      lat = 1;
      return;
    end
    base = addr - (addr % n);
    if (!wr) begin
      v = 32'h0;
      for (int unsigned i = 0; i < n; i++) v |= 32'(ref_b[base+i]) << (8*i);
      if (n < 4 && !uns && v[8*n-1]) v |= ~((32'd1 << (8*n)) - 32'd1);
      rd  = v;
      lat = 2;
    end else begin
      for (int unsigned i = 0; i < n; i++) ref_b[base+i] = 8'(wdata >> (8*i));
      lat = (n == 4) ? 2 : 3;
    end
  endtask

  // Monitor: pops the scoreboard whenever a response pulse is presented.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1) begin
      chk("rd_wr_exclusive", 32'(mem_read & mem_write), 32'h0);
      if (resp_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_resp", 32'(resp_valid), 32'h0);
        end else begin
          e = q.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_error", 32'(resp_error), 32'(e.err));
          chk("resp_latency", cyc - e.acc, e.lat);
        end
      end
    end
  end

  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int unsigned waited;
    logic exp_rd, exp_wr;
    waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      chk("ready_timeout", 32'(req_ready), 32'h1);
      return;
    end
    req_valid = 1'b1; req_write = wr; req_size = sz;
    req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    model(wr, sz, uns, addr, wdata, e.rdata, e.err, e.lat);
    e.acc = cyc;
    q.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    exp_rd = !e.err && (!wr || sz != 2'b10);
    exp_wr = !e.err && wr && sz == 2'b10;
    chk("phase1_read", 32'(mem_read), 32'(exp_rd));
    chk("phase1_write", 32'(mem_write), 32'(exp_wr));
    if (!e.err) chk("mem_addr", mem_addr, addr >> 2);
    if (!e.err && wr && sz != 2'b10) begin
      @(negedge clk);
      chk("rmw_write", 32'(mem_write), 32'h1);
      chk("rmw_read", 32'(mem_read), 32'h0);
    end
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", q.size(), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w, word3_before;
    logic [1:0]  sz;
    logic [31:0] addr;
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    for (int unsigned i = 0; i < 256; i++) begin
      w = (i == 3) ? 32'h8899AABB : $urandom;
      mem[i] = w;
      for (int unsigned b = 0; b < 4; b++) ref_b[4*i+b] = 8'(w >> (8*b));
    end
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_error", 32'(resp_error), 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_write", 32'(mem_write), 32'h0);
    chk("rst_mem_read", 32'(mem_read), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    reset = 1'b1;

    issue(1'b0, 2'b00, 1'b0, 32'h0D, 32'h0);         // LB  -> FFFFFFAA
    issue(1'b0, 2'b00, 1'b1, 32'h0D, 32'h0);         // LBU -> 000000AA
    issue(1'b0, 2'b01, 1'b0, 32'h0E, 32'h0);         // LH  -> FFFF8899
    issue(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);         // LW
    issue(1'b1, 2'b01, 1'b0, 32'h0E, 32'h00001234);  // SH
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);  // SW
    issue(1'b0, 2'b10, 1'b0, 32'h06, 32'h0);         // misaligned LW
    issue(1'b1, 2'b00, 1'b0, 32'h400, 32'h55);       // out of range
    issue(1'b0, 2'b11, 1'b0, 32'h08, 32'h0);         // illegal size
    issue(1'b0, 2'b10, 1'b1, 32'h0C, 32'h0);
    drain();
    chk("word3_after_sh", mem[3], 32'h1234AABB);
    chk("word4_after_sw", mem[4], 32'hDEADBEEF);

    // Reset while the read half of a byte store is in flight.
    word3_before = mem[3];
    @(negedge clk);
    write_seen = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0C; req_wdata = 32'h000000C3;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_rd_read", 32'(mem_read), 32'h1);
    reset = 1'b0;
    #1;
    chk("midrst_mem_read", 32'(mem_read), 32'h0);
    chk("midrst_mem_write", 32'(mem_write), 32'h0);
    chk("midrst_resp_valid", 32'(resp_valid), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'h1);
    chk("rst_write_seen", 32'(write_seen), 32'h0);
    chk("rst_word3_kept", mem[3], word3_before);

    for (int unsigned n = 0; n < 300; n++) begin
      sz   = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      addr = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(1024, 2047))
                                         : 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, $urandom);
    end
    drain();

    for (int unsigned i = 0; i < 256; i++) chk($sformatf("mem_word_%0d", i), mem[i], ref_word(i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
